gf128_inv: RTL and testbench

- Iterative GF(2^128) inverter: returns a^-1 = a^(2^128-2) mod P(x) = x^128 + x^7 + x^2 + x + 1 (the GCM field).
- It is the inverse-direction companion of the 128-bit field multiplier and reduction path, and it feeds division and key-setup logic.
- Computes by a Fermat chain: 127 squarings (combinational) plus 127 digit-serial multiplications.
- Valid/ready handshake on input and output; one operand in flight at a time.

---
 rtl/gf128_pkg.sv | 42 ++++
 rtl/gf128_inv_if.sv | 22 ++
 rtl/gf128_mul_digit.sv | 69 ++++++
 rtl/gf128_inv.sv | 92 +++++++++
 tb/tb_gf128_inv.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf128_pkg.sv
// Shared GF(2^128) definitions for the inverter: field constants, FSM states
// and the combinational squaring / x^d-shift helpers.
package gf128_pkg;

  localparam int unsigned GF_W = 128;
  localparam logic [GF_W-1:0] POLY_LO = 128'h87;
  localparam logic [6:0] ITER_LAST = 7'd126;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_e;

  // v * x^d mod P, one reduction per shifted-out bit.
  function automatic logic [GF_W-1:0] gf_mulx_d(input logic [GF_W-1:0] v, input int unsigned d);
    logic [GF_W-1:0] t;
    t = v;
    for (int unsigned i = 0; i < d; i++) begin
      t = {t[GF_W-2:0], 1'b0} ^ (t[GF_W-1] ? POLY_LO : '0);
    end
    return t;
  endfunction

  // Squaring in characteristic 2 just spreads the bits; fold the top half back down.
  function automatic logic [GF_W-1:0] gf_sqr(input logic [GF_W-1:0] v);
    logic [2*GF_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < GF_W; i++) begin
      w[2*i] = v[i];
    end
    for (int unsigned i = 2*GF_W-2; i >= GF_W; i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-GF_W +: 8] = w[i-GF_W +: 8] ^ POLY_LO[7:0];
      end
    end
    return w[GF_W-1:0];
  endfunction

endpackage

// File: rtl/gf128_inv_if.sv
// Operand/result handshake bundle of the GF(2^128) inverter.
interface gf128_inv_if;
  import gf128_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [GF_W-1:0] a;
  logic            out_valid;
  logic            out_ready;
  logic [GF_W-1:0] inv;
  logic            zero_in;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, inv, zero_in
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, inv, zero_in
  );
endinterface

// File: rtl/gf128_mul_digit.sv
// Digit-serial GF(2^128) multiplier: p = a*b mod P over NDIG cycles, MSB digit of b first.
// Operands must stay stable while busy; done flags the cycle in which p is the full product.
module gf128_mul_digit
  import gf128_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [GF_W-1:0] p
);

  localparam int unsigned NDIG = GF_W / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
        DIGIT == 16 || DIGIT == 32 || DIGIT == 64 || DIGIT == 128)) begin : g_bad_digit
    $error("gf128_mul_digit: DIGIT must be a power of two between 1 and 128");
  end

  logic [GF_W-1:0]  acc_q, acc_d;
  logic [GF_W-1:0]  part, t;
  logic [DIGIT-1:0] digit;
  logic [CW-1:0]    dcnt_q;
  logic             busy_q;
  logic             last;

  always_comb begin
    digit = DIGIT'(b >> ((NDIG - 1 - 32'(dcnt_q)) * DIGIT));
    part  = '0;
    t     = a;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      if (digit[j]) part = part ^ t;
      t = gf_mulx_d(t, 1);
    end
    acc_d = gf_mulx_d(acc_q, DIGIT) ^ part;
  end

  assign last = (dcnt_q == CW'(NDIG - 1));
  assign busy = busy_q;
  assign done = busy_q && last;
  assign p    = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dcnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      dcnt_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      if (last) begin
        busy_q <= 1'b0;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gf128_inv.sv
// Iterative GF(2^128) inverter, a^(2^128-2) mod x^128+x^7+x^2+x+1, by a Fermat
// chain of 127 (square, digit-serial multiply) rounds; one operand in flight.
module gf128_inv
  import gf128_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  gf128_inv_if.slave  bus
);

  state_e          state_q;
  logic [GF_W-1:0] s_q, r_q, inv_q;
  logic [6:0]      cnt_q;
  logic            zflag_q, zero_q;
  logic            in_ready_q, out_valid_q;

  logic            mul_busy, mul_done;
  logic [GF_W-1:0] mul_p;

  // Multiplier samples r and s live: neither changes between SQR exit and the last MUL cycle.
  gf128_mul_digit #(.DIGIT(DIGIT)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == SQR),
    .a     (r_q),
    .b     (s_q),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      inv_q       <= '0;
      zero_q      <= 1'b0;
      zflag_q     <= 1'b0;
      s_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            s_q        <= bus.a;
            r_q        <= GF_W'(1);
            cnt_q      <= '0;
            zflag_q    <= (bus.a == '0);
            in_ready_q <= 1'b0;
            state_q    <= SQR;
          end
        end
        SQR: begin
          s_q     <= gf_sqr(s_q);
          state_q <= MUL;
        end
        MUL: begin
          if (mul_busy && mul_done) begin
            r_q   <= mul_p;
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q == ITER_LAST) begin
              out_valid_q <= 1'b1;
              inv_q       <= mul_p;
              zero_q      <= zflag_q;
              state_q     <= DONE;
            end else begin
              state_q <= SQR;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.inv       = inv_q;
  assign bus.zero_in   = zero_q;

endmodule

// File: tb/tb_gf128_inv.sv
// Bench for gf128_inv at DIGIT = 8, 1 and 128 against a bit-serial GF(2^128) model.
module tb_gf128_inv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Index 0: DIGIT=8, 1: DIGIT=1, 2: DIGIT=128
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [127:0] a_in [3];
  wire  [2:0]   in_ready_w;
  wire  [2:0]   out_valid_w;
  wire  [2:0]   zero_w;
  wire  [127:0] inv_w [3];

  gf128_inv_if if8 ();
  gf128_inv_if if1 ();
  gf128_inv_if if128 ();

  assign if8.in_valid   = in_valid[0];
  assign if8.a          = a_in[0];
  assign if8.out_ready  = out_ready[0];
  assign if1.in_valid   = in_valid[1];
  assign if1.a          = a_in[1];
  assign if1.out_ready  = out_ready[1];
  assign if128.in_valid  = in_valid[2];
  assign if128.a         = a_in[2];
  assign if128.out_ready = out_ready[2];

  assign in_ready_w  = {if128.in_ready, if1.in_ready, if8.in_ready};
  assign out_valid_w = {if128.out_valid, if1.out_valid, if8.out_valid};
  assign zero_w      = {if128.zero_in, if1.zero_in, if8.zero_in};
  assign inv_w[0]    = if8.inv;
  assign inv_w[1]    = if1.inv;
  assign inv_w[2]    = if128.inv;

  gf128_inv #(.DIGIT(8))   u_d8   (.clk(clk), .rst(rst), .bus(if8));
  gf128_inv #(.DIGIT(1))   u_d1   (.clk(clk), .rst(rst), .bus(if1));
  gf128_inv #(.DIGIT(128)) u_d128 (.clk(clk), .rst(rst), .bus(if128));

  // Reference: schoolbook carry-less product, reducing after every shift.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] acc, sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < 128; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh[127] ? ((sh << 1) ^ 128'h87) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic int exp_lat(input int idx);
    int d;
    d = (idx == 0) ? 8 : (idx == 1) ? 1 : 128;
    return 127 * (1 + 128 / d);
  endfunction

  function automatic logic [127:0] rand_nz();
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (v == '0) v = 128'h1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [127:0] av, output int t0, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (in_ready_w[idx] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (in_ready_w[idx] !== 1'b1) to = 1'b1;
    in_valid[idx] = 1'b1;
    a_in[idx]     = av;
    tick();
    in_valid[idx] = 1'b0;
    a_in[idx]     = {$urandom(), $urandom(), $urandom(), $urandom()};
    t0 = cyc;
  endtask

  // Waits for out_valid while toggling the ignored inputs.
  task automatic wait_result(input int idx, input int t0, output int lat, output bit to);
    int n;
    n = 0;
    while (out_valid_w[idx] !== 1'b1 && n < 20000) begin
      in_valid[idx]  = 1'($urandom_range(1));
      out_ready[idx] = 1'($urandom_range(1));
      tick();
      n++;
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
    to  = (out_valid_w[idx] !== 1'b1);
    lat = cyc - t0;
  endtask

  task automatic release_out(input int idx);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready_w !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b want 111", in_ready_w); end
    n_checks++;
    if (out_valid_w !== 3'b000) begin n_fail++; $display("FAIL reset_out_valid: got %b want 000", out_valid_w); end
    n_checks++;
    if (zero_w !== 3'b000) begin n_fail++; $display("FAIL reset_zero_in: got %b want 000", zero_w); end
    n_checks++;
    if (inv_w[0] !== 128'h0) begin n_fail++; $display("FAIL reset_inv: got %h want 0", inv_w[0]); end
  endtask

  task automatic test_one();
    int t0, lat;
    bit to1, to2;
    send(0, 128'h1, t0, to1);
    wait_result(0, t0, lat, to2);
    n_checks++;
    if ((to1 | to2) !== 1'b0) begin n_fail++; $display("FAIL one_timeout: got %b want 0", to1 | to2); end
    n_checks++;
    if (lat !== 2159) begin n_fail++; $display("FAIL one_latency: got %0d want 2159", lat); end
    n_checks++;
    if (inv_w[0] !== 128'h1) begin n_fail++; $display("FAIL one_inv: got %h want 1", inv_w[0]); end
    n_checks++;
    if (zero_w[0] !== 1'b0) begin n_fail++; $display("FAIL one_zero_in: got %b want 0", zero_w[0]); end
    release_out(0);
  endtask

  task automatic test_x();
    int t0, lat;
    bit to1, to2;
    logic [127:0] r;
    send(0, 128'h2, t0, to1);
    wait_result(0, t0, lat, to2);
    r = inv_w[0];
    n_checks++;
    if (r !== 128'h8000_0000_0000_0000_0000_0000_0000_0043) begin
      n_fail++; $display("FAIL x_inv: got %h want 80000000000000000000000000000043", r);
    end
    n_checks++;
    if (gf_mul(128'h2, r) !== 128'h1) begin n_fail++; $display("FAIL x_product: got %h want 1", gf_mul(128'h2, r)); end
    release_out(0);
  endtask

  task automatic test_zero();
    int t0, lat;
    bit to1, to2;
    send(0, 128'h0, t0, to1);
    wait_result(0, t0, lat, to2);
    n_checks++;
    if (lat !== 2159) begin n_fail++; $display("FAIL zero_latency: got %0d want 2159", lat); end
    n_checks++;
    if (inv_w[0] !== 128'h0) begin n_fail++; $display("FAIL zero_inv: got %h want 0", inv_w[0]); end
    n_checks++;
    if (zero_w[0] !== 1'b1) begin n_fail++; $display("FAIL zero_flag: got %b want 1", zero_w[0]); end
    release_out(0);
    send(0, 128'h1, t0, to1);
    wait_result(0, t0, lat, to2);
    n_checks++;
    if (zero_w[0] !== 1'b0) begin n_fail++; $display("FAIL zero_after_flag: got %b want 0", zero_w[0]); end
    n_checks++;
    if (inv_w[0] !== 128'h1) begin n_fail++; $display("FAIL zero_after_inv: got %h want 1", inv_w[0]); end
    release_out(0);
  endtask

  task automatic test_backpressure();
    int t0, lat, bad;
    bit to1, to2;
    logic [127:0] av, inv0;
    logic z0;
    av = rand_nz();
    send(0, av, t0, to1);
    wait_result(0, t0, lat, to2);
    inv0 = inv_w[0];
    z0   = zero_w[0];
    bad  = 0;
    repeat (500) begin
      in_valid[0] = 1'($urandom_range(1));
      tick();
      if (inv_w[0] !== inv0 || zero_w[0] !== z0 || in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1) bad++;
    end
    in_valid[0] = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    n_checks++;
    if (gf_mul(av, inv0) !== 128'h1) begin n_fail++; $display("FAIL bp_product: got %h want 1", gf_mul(av, inv0)); end
    release_out(0);
    n_checks++;
    if ({in_ready_w[0], out_valid_w[0]} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got in_ready,out_valid=%b want 10", {in_ready_w[0], out_valid_w[0]});
    end
    tick();
    n_checks++;
    if ({in_ready_w[0], out_valid_w[0]} !== 2'b10) begin
      n_fail++; $display("FAIL bp_idle: got in_ready,out_valid=%b want 10", {in_ready_w[0], out_valid_w[0]});
    end
  endtask

  task automatic test_reset_mid();
    int t0, lat;
    bit to1, to2;
    send(0, 128'h2, t0, to1);
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready_w[0], out_valid_w[0], zero_w[0]} !== 3'b100) begin
      n_fail++; $display("FAIL rmid_flags: got in_ready,out_valid,zero_in=%b want 100",
                         {in_ready_w[0], out_valid_w[0], zero_w[0]});
    end
    n_checks++;
    if (inv_w[0] !== 128'h0) begin n_fail++; $display("FAIL rmid_inv: got %h want 0", inv_w[0]); end
    send(0, 128'h1, t0, to1);
    wait_result(0, t0, lat, to2);
    n_checks++;
    if (inv_w[0] !== 128'h1) begin n_fail++; $display("FAIL rmid_after_inv: got %h want 1", inv_w[0]); end
    n_checks++;
    if (lat !== 2159) begin n_fail++; $display("FAIL rmid_after_latency: got %0d want 2159", lat); end
    release_out(0);
  endtask

  task automatic test_random(input int idx, input int n);
    int t0, lat, gap;
    bit to1, to2;
    logic [127:0] av, r;
    for (int k = 0; k < n; k++) begin
      av = rand_nz();
      send(idx, av, t0, to1);
      wait_result(idx, t0, lat, to2);
      r = inv_w[idx];
      n_checks++;
      if ((to1 | to2) !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b want 0", idx, to1 | to2); end
      n_checks++;
      if (lat !== exp_lat(idx)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", idx, lat, exp_lat(idx)); end
      n_checks++;
      if (gf_mul(av, r) !== 128'h1) begin
        n_fail++; $display("FAIL rand%0d_product: a=%h inv=%h got %h want 1", idx, av, r, gf_mul(av, r));
      end
      n_checks++;
      if (zero_w[idx] !== 1'b0) begin n_fail++; $display("FAIL rand%0d_zero_in: got %b want 0", idx, zero_w[idx]); end
      gap = $urandom_range(0, 20);
      repeat (gap) tick();
      release_out(idx);
    end
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) a_in[i] = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_one();
    test_x();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random(0, 6);
    test_random(2, 30);
    test_random(1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
